// File: rtl/freq_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module  : freq_sweep_pkg
// Brief   : State encoding and default widths shared by the sweep sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package freq_sweep_pkg;

   localparam int DEF_CODE_W  = 3;
   localparam int DEF_DWELL_W = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_LOAD = ST_LOAD,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dwell_counter.sv
`default_nettype none
// ============================================================================
// Module  : dwell_counter
// Brief   : Tick counter with latched target; hit flags the completing tick.
// Rev     : 1.0  initial release
// ============================================================================
module dwell_counter
   import freq_sweep_pkg::*;
#(
   parameter int DWELL_W = DEF_DWELL_W
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [DWELL_W-1:0] target,
   input  logic               clr,
   input  logic               en,
   output logic               hit
);

   logic [DWELL_W-1:0] target_q, target_d;
   logic [DWELL_W-1:0] count_q, count_d;

   // target-1 wraps for a zero target, giving 2^DWELL_W ticks
   assign hit = en && (count_q == (target_q - DWELL_W'(1)));

   always_comb begin
      target_d = target_q;
      count_d  = count_q;
      if (load) begin
         target_d = target;
      end
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + DWELL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_q <= '0;
         count_q  <= '0;
      end else begin
         target_q <= target_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/freq_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : freq_sweep_ctrl
// Brief   : Steps the divider load code from start to stop, dwelling a set
//           number of terminal-count ticks per code. FREQ_SWEEP_LOOP_EN makes
//           the sweep repeat until abort or reset.
// Rev     : 1.0  initial release
// ============================================================================
module freq_sweep_ctrl
   import freq_sweep_pkg::*;
#(
   parameter int CODE_W  = DEF_CODE_W,
   parameter int DWELL_W = DEF_DWELL_W
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [CODE_W-1:0]  start_code,
   input  logic [CODE_W-1:0]  stop_code,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               sel_cfg,
   input  logic               tick,
   output logic               init,
   output logic               select,
   output logic [CODE_W-1:0]  cnt,
   output logic               busy,
   output logic               done,
   output logic [CODE_W:0]    step_idx
);

   state_t            state_q, state_d;
   logic              init_q, init_d;
   logic              select_q, select_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              up_q, up_d;
   logic [CODE_W-1:0] cnt_q, cnt_d;
   logic [CODE_W-1:0] stop_q, stop_d;
   logic [CODE_W:0]   step_idx_q, step_idx_d;
`ifdef FREQ_SWEEP_LOOP_EN
   logic [CODE_W-1:0] first_q, first_d;
`endif

   logic accept;
   logic dwell_hit;

   assign accept = (state_q == S_IDLE) && start && !abort;

   dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
      .clk    (clk),
      .rst_n  (reset),
      .load   (accept),
      .target (dwell),
      .clr    (state_q == S_LOAD),
      .en     ((state_q == S_RUN) && tick),
      .hit    (dwell_hit)
   );

   always_comb begin
      state_d    = state_q;
      init_d     = 1'b0;
      done_d     = 1'b0;
      busy_d     = busy_q;
      select_d   = select_q;
      up_d       = up_q;
      cnt_d      = cnt_q;
      stop_d     = stop_q;
      step_idx_d = step_idx_q;
`ifdef FREQ_SWEEP_LOOP_EN
      first_d    = first_q;
`endif
      // abort wins over everything, including a coincident dwell completion
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  state_d    = S_LOAD;
                  init_d     = 1'b1;
                  busy_d     = 1'b1;
                  select_d   = sel_cfg;
                  up_d       = (stop_code >= start_code);
                  cnt_d      = start_code;
                  stop_d     = stop_code;
                  step_idx_d = '0;
`ifdef FREQ_SWEEP_LOOP_EN
                  first_d    = start_code;
`endif
               end
            end
            S_LOAD: begin
               state_d = S_RUN;
            end
            S_RUN: begin
               if (dwell_hit) begin
                  step_idx_d = step_idx_q + (CODE_W+1)'(1);
                  if (cnt_q == stop_q) begin
`ifdef FREQ_SWEEP_LOOP_EN
                     state_d    = S_LOAD;
                     init_d     = 1'b1;
                     done_d     = 1'b1;
                     cnt_d      = first_q;
                     step_idx_d = '0;
`else
                     state_d    = S_DONE;
                     done_d     = 1'b1;
`endif
                  end else begin
                     state_d = S_LOAD;
                     init_d  = 1'b1;
                     cnt_d   = up_q ? (cnt_q + CODE_W'(1)) : (cnt_q - CODE_W'(1));
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
            default: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         init_q     <= 1'b0;
         select_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         up_q       <= 1'b0;
         cnt_q      <= '0;
         stop_q     <= '0;
         step_idx_q <= '0;
`ifdef FREQ_SWEEP_LOOP_EN
         first_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         init_q     <= init_d;
         select_q   <= select_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         up_q       <= up_d;
         cnt_q      <= cnt_d;
         stop_q     <= stop_d;
         step_idx_q <= step_idx_d;
`ifdef FREQ_SWEEP_LOOP_EN
         first_q    <= first_d;
`endif
      end
   end

   assign init     = init_q;
   assign select   = select_q;
   assign cnt      = cnt_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign step_idx = step_idx_q;

endmodule
`default_nettype wire

// File: doc/freq_sweep_ctrl.md
# freq_sweep_ctrl

Sequencer for the DDS frequency divider: steps the divider's 3-bit load code from a start code to a stop code and holds each code for a programmable number of divider terminal-count ticks. It drives the divider's `init`, `select` and `cnt` inputs and watches its terminal-count pulse. A single start/busy/done handshake serves the lab top-level control logic. It sits between the top-level control logic and `freq_divider`.

## Interface
- `CODE_W`, default 3: width of the divider load code.
- `DWELL_W`, default 8: width of the dwell tick count.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: sweep request, sampled only in IDLE.
- `abort` in 1: terminates a sweep in progress.
- `start_code` in CODE_W: first divider code.
- `stop_code` in CODE_W: last divider code.
- `dwell` in DWELL_W: ticks per code; 0 means 2^DWELL_W.
- `sel_cfg` in 1: divider output-mux selection for the sweep.
- `tick` in 1: divider terminal-count pulse (`co1`), synchronous to `clk`.
- `init` out 1: divider reload strobe.
- `select` out 1: divider mux select.
- `cnt` out CODE_W: divider load code.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle sweep-complete pulse.
- `step_idx` out CODE_W+1: number of codes completed in the current sweep.

## Operation
States: IDLE, LOAD, RUN, DONE. All outputs are registered.

- **IDLE**
  - On `start` = 1 with `abort` = 0, the block latches `start_code`, `stop_code`, `dwell` and `sel_cfg`.
  - The direction is latched as up = (`stop_code` >= `start_code`).
  - `cnt` takes `start_code` and `step_idx` clears to 0. Next state is LOAD.
- **LOAD**
  - `init` = 1 for exactly this one cycle.
  - The dwell counter is cleared.
  - `tick` is ignored in this cycle because the divider is reloading.
  - Next state is RUN.
- **RUN**
  - Each cycle with `tick` = 1 increments the dwell counter.
  - On the tick that makes the count equal the latched dwell (0 treated as 2^DWELL_W), `step_idx` increments.
  - If `cnt` equals the latched stop code, next state is DONE.
  - Otherwise `cnt` steps by +1 (up) or −1 (down) and next state is LOAD.
  - `cnt` never wraps: equal start/stop codes give a single-code sweep.
- **DONE**
  - `done` = 1 for one cycle. Next state is IDLE.
- **Handshake and signal rules**
  - `busy` = 1 in LOAD, RUN and DONE; it falls on the cycle after DONE.
  - `start` while not in IDLE is ignored; input codes may change freely after the start cycle.
  - `abort` = 1 in LOAD, RUN or DONE forces IDLE on the next edge. No `done` pulse is issued, `init` is forced to 0, and `cnt`, `select` and `step_idx` hold their values.
  - `abort` has priority over a simultaneous dwell completion.
  - `select` takes the latched `sel_cfg` in the start cycle and holds it until the next start.
- **Reset**
  - Asserting `reset` low at any time, including mid-sweep, forces IDLE immediately.
  - Reset values: `init` = 0, `select` = 0, `cnt` = 0, `busy` = 0, `done` = 0, `step_idx` = 0.
  - The dwell counter clears to 0.

## Timing
- Start cycle T (IDLE, `start` = 1): at T+1, `busy` = 1 and `init` = 1; `cnt` and `select` are valid at T+1.
- Code change: the new `cnt` and its `init` appear on the same edge, one cycle after the final dwell tick.
- Code transitions carry no lost ticks beyond the LOAD cycle.
- With the divider period P cycles per tick and dwell D, each code occupies 1 + D·P cycles, measured from `init` to the next `init` or DONE entry.
- `done` asserts one cycle after the final dwell tick; `busy` falls one cycle after `done`.
- Back-to-back sweeps: a `start` sampled in the first IDLE cycle after DONE is accepted.

## Configuration
- **`FREQ_SWEEP_LOOP_EN` defined:** on reaching the stop code, the block re-enters LOAD with `cnt` = latched start code instead of entering DONE. `done` pulses for one cycle on that same LOAD cycle, `step_idx` clears to 0, and `busy` stays 1. The sweep repeats until `abort` or `reset`.
- **Undefined:** single-shot behaviour as described in Operation.

## Structure
- Package `freq_sweep_pkg`:
  - State encoding constants: IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3.
  - Default `CODE_W` and `DWELL_W`.
- Sub-module `dwell_counter`: parameterised DWELL_W up-counter with synchronous clear, tick enable, latched target and a one-cycle `hit` output. It instantiates once. The FSM, code stepping and handshake stay in the top module.

## Test plan
- **Reset mid-RUN:** assert `reset` low during a sweep → all outputs 0 in the same cycle, IDLE after release, no `done` pulse.
- **Up sweep:** `start_code` = 2, `stop_code` = 4, `dwell` = 3, `tick` every 4 cycles → `cnt` sequence 2, 3, 4. Exactly one `init` pulse per code, 3 ticks counted per code, `done` one cycle after the 9th counted tick, `step_idx` = 3 at `done`.
- **Down sweep:** `start_code` = 5, `stop_code` = 5 → single code, `init` once, `done` after `dwell` ticks. Then `start_code` = 6, `stop_code` = 1 → `cnt` sequence 6, 5, 4, 3, 2, 1 with no wrap.
- **Dwell zero and LOAD tick:** `dwell` = 0 → 256 ticks per code. A `tick` coincident with LOAD is not counted.
- **Abort and ignored start:** `abort` asserted on the same cycle as the final dwell tick → IDLE next cycle, no `done`, `cnt` held. A `start` pulse while `busy` = 1 has no effect.
- **Loop mode (`FREQ_SWEEP_LOOP_EN`):** `start_code` = 1, `stop_code` = 2 → `cnt` sequence 1, 2, 1, 2… with `done` pulsing at each return to 1 and `busy` held at 1 until `abort`.
